// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one sequential multiplier between two requesters. A round-robin
// arbiter picks an owner, the owner's operands are latched, then fed to the
// multiplier as two load pulses (A then B) separated by gap cycles so the
// multiplier's load one-shot re-arms. A start pulse follows, the arbiter
// waits for mul_ready, captures mul_result and pulses done for the owner.
//
// Parameters
//   WORD_LENGTH : operand width of the shared multiplier
//   TIMEOUT     : maximum WAIT cycles before aborting (timeout build only)
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous active-low reset
//   req_0/req_1         : operation requests
//   a_0/a_1, b_0/b_1    : operands per requester
//   op_0/op_1           : add/sub select per requester
//   grant_0/grant_1     : current owner of the multiplier
//   done_0/done_1       : one-cycle completion pulses
//   result              : last captured product
//   error               : last operation timed out
//   busy                : arbiter not idle
//   mul_load/mul_data   : operand load strobe and data to the multiplier
//   mul_start/mul_op    : start strobe and op select to the multiplier
//   mul_ready/mul_result: multiplier completion flag and product
//
// Build option
//   MULT_ARB_TIMEOUT_EN : when defined, WAIT is bounded by TIMEOUT cycles;
//                         on expiry the operation finishes with result=0
//                         and error=1. When undefined, error is tied low
//                         and no counter exists.
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int WORD_LENGTH = 5,
    parameter int TIMEOUT     = 4*WORD_LENGTH+8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_0,
    input  logic                     req_1,
    input  logic [WORD_LENGTH-1:0]   a_0,
    input  logic [WORD_LENGTH-1:0]   a_1,
    input  logic [WORD_LENGTH-1:0]   b_0,
    input  logic [WORD_LENGTH-1:0]   b_1,
    input  logic                     op_0,
    input  logic                     op_1,
    output logic                     grant_0,
    output logic                     grant_1,
    output logic                     done_0,
    output logic                     done_1,
    output logic [2*WORD_LENGTH-1:0] result,
    output logic                     error,
    output logic                     busy,
    output logic                     mul_load,
    output logic                     mul_start,
    output logic                     mul_op,
    output logic [WORD_LENGTH-1:0]   mul_data,
    input  logic                     mul_ready,
    input  logic [2*WORD_LENGTH-1:0] mul_result
);

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        LOAD_A,
        GAP_A,
        LOAD_B,
        GAP_B,
        START,
        WAIT,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;   // 0 = port 0, 1 = port 1
    logic                     last_q, last_d;     // port served most recently
    logic [WORD_LENGTH-1:0]   a_q, a_d;
    logic [WORD_LENGTH-1:0]   b_q, b_d;
    logic                     op_q, op_d;
    logic [2*WORD_LENGTH-1:0] result_q, result_d;
    logic                     pick;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        pick     = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d    = '0;
        error_d  = error_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    // Contention goes to the port not served last; a lone
                    // request is granted directly.
                    pick    = (req_0 && req_1) ? ~last_q : req_1;
                    owner_d = pick;
                    last_d  = pick;
                    // Operands are captured on entry to GRANT so they are
                    // stable for the whole operation, mul_op included.
                    a_d     = pick ? a_1  : a_0;
                    b_d     = pick ? b_1  : b_0;
                    op_d    = pick ? op_1 : op_0;
                    state_d = GRANT;
                end
            end
            GRANT:  state_d = LOAD_A;
            LOAD_A: state_d = GAP_A;
            GAP_A:  state_d = LOAD_B;
            LOAD_B: state_d = GAP_B;
            GAP_B:  state_d = START;
            START:  state_d = WAIT;
            WAIT: begin
                if (mul_ready) begin
                    // Captured on entry to DONE so result is valid while
                    // done pulses.
                    result_d = mul_result;
`ifdef MULT_ARB_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                    state_d  = DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;   // favours port 0 on the first contention
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Outputs decode straight from the state register so an asserted reset
    // drops them without waiting for a clock edge.
    always_comb begin
        busy      = (state_q != IDLE);
        grant_0   = busy && !owner_q;
        grant_1   = busy &&  owner_q;
        mul_load  = (state_q == LOAD_A) || (state_q == LOAD_B);
        mul_start = (state_q == START);
        mul_op    = busy ? op_q : 1'b0;
        done_0    = (state_q == DONE) && !owner_q;
        done_1    = (state_q == DONE) &&  owner_q;
        mul_data  = '0;
        if (state_q == LOAD_A) mul_data = a_q;
        if (state_q == LOAD_B) mul_data = b_q;
    end

    assign result = result_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int W  = 5;
    localparam int TO = 4*W+8;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_0, req_1;
    logic [W-1:0]   a_0, a_1, b_0, b_1;
    logic           op_0, op_1;
    logic           grant_0, grant_1, done_0, done_1;
    logic [2*W-1:0] result;
    logic           error, busy;
    logic           mul_load, mul_start, mul_op;
    logic [W-1:0]   mul_data;
    logic           mul_ready;
    logic [2*W-1:0] mul_result;

    always #5 clk = ~clk;

    mult_share_arbiter #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .req_1     (req_1),
        .a_0       (a_0),
        .a_1       (a_1),
        .b_0       (b_0),
        .b_1       (b_1),
        .op_0      (op_0),
        .op_1      (op_1),
        .grant_0   (grant_0),
        .grant_1   (grant_1),
        .done_0    (done_0),
        .done_1    (done_1),
        .result    (result),
        .error     (error),
        .busy      (busy),
        .mul_load  (mul_load),
        .mul_start (mul_start),
        .mul_op    (mul_op),
        .mul_data  (mul_data),
        .mul_ready (mul_ready),
        .mul_result(mul_result)
    );

    // ---------------- multiplier model ----------------
    int                    mdl_delay = 6;
    logic                  mdl_stuck = 1'b0;
    int                    mdl_cnt;
    logic [W-1:0]          ma, mb;
    logic                  msel;
    logic signed [2*W-1:0] mprod;

    assign mprod      = $signed(ma) * $signed(mb);
    assign mul_result = mprod;

    always @(posedge clk) begin
        if (!reset) begin
            mul_ready <= 1'b0;
            mdl_cnt   <= 0;
            msel      <= 1'b0;
            ma        <= '0;
            mb        <= '0;
        end else begin
            if (mul_load) begin
                if (!msel) ma <= mul_data;
                else       mb <= mul_data;
                msel <= ~msel;
            end
            if (mul_start) begin
                msel <= 1'b0;
                if (!mdl_stuck && mdl_delay == 0) begin
                    mul_ready <= 1'b1;
                end else begin
                    mul_ready <= 1'b0;
                    mdl_cnt   <= mdl_delay;
                end
            end else if (mdl_cnt > 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1 && !mdl_stuck) mul_ready <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic           port;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           op;
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic port, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic op, input logic err);
        exp_t                  e;
        logic signed [2*W-1:0] p;
        p     = $signed(a) * $signed(b);
        e.port = port;
        e.a    = a;
        e.b    = b;
        e.op   = op;
        e.err  = err;
        e.res  = err ? '0 : p;
        return e;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return grant_0;
            1:       return grant_1;
            2:       return mul_start;
            default: return done_0 | done_1;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 64'(0), 64'(1));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        if (sbq.size() != 0) chk(tag, 64'(sbq.size()), 64'(0));
    endtask

    // ---------------- output monitor ----------------
    int           nload, nstart;
    logic [W-1:0] ld_v [2];
    logic         prev_done;
    exp_t         me;

    initial begin
        nload = 0; nstart = 0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nload = 0; nstart = 0; prev_done = 1'b0;
            end else begin
                if (busy) chk("grant_excl", 64'(grant_0 & grant_1), 64'(0));
                if (prev_done) chk("done_width", 64'(done_0 | done_1), 64'(0));
                prev_done = done_0 | done_1;
                if (mul_load) begin
                    if (nload < 2) ld_v[nload] = mul_data;
                    nload++;
                end
                if (mul_start) nstart++;
                if (done_0 | done_1) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_done", 64'(1), 64'(0));
                    end else begin
                        me = sbq.pop_front();
                        chk("done_port",  64'({done_1, done_0}),   64'(me.port ? 2 : 1));
                        chk("done_grant", 64'({grant_1, grant_0}), 64'(me.port ? 2 : 1));
                        chk("result",     64'(result),   64'(me.res));
                        chk("error",      64'(error),    64'(me.err));
                        chk("mul_op",     64'(mul_op),   64'(me.op));
                        chk("n_load",     64'(nload),    64'(2));
                        chk("load_a",     64'(ld_v[0]),  64'(me.a));
                        chk("load_b",     64'(ld_v[1]),  64'(me.b));
                        chk("n_start",    64'(nstart),   64'(1));
                    end
                    nload = 0; nstart = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic seen;
        reset = 1'b0;
        req_0 = 1'b0; req_1 = 1'b0;
        a_0 = '0; a_1 = '0; b_0 = '0; b_1 = '0; op_0 = 1'b0; op_1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({busy, grant_0, grant_1, done_0, done_1, mul_load, mul_start, mul_op, error}), 64'(0));
        chk("rst_data", 64'(mul_data), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 64'({busy, mul_load, mul_start}), 64'(0));

        // Basic op: 3 * -2
        mdl_delay = 6;
        sbq.push_back(mk(1'b0, 5'd3, 5'h1E, 1'b0, 1'b0));
        a_0 = 5'd3; b_0 = 5'h1E; op_0 = 1'b0; req_0 = 1'b1;
        wait_sig(0, "t1_grant");
        req_0 = 1'b0;
        wait_sig(3, "t1_done");
        chk("t1_result", 64'(result), 64'(10'h3FA));
        drain("t1_drain");
        repeat (2) @(negedge clk);
        chk("t1_result_hold", 64'(result), 64'(10'h3FA));

        // Minimum latency with mul_ready already high on entering WAIT
        mdl_delay = 0;
        sbq.push_back(mk(1'b0, 5'd5, 5'd6, 1'b1, 1'b0));
        a_0 = 5'd5; b_0 = 5'd6; op_0 = 1'b1; req_0 = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (grant_0) req_0 = 1'b0;
            if (done_0 | done_1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("latency_seen", 64'(seen), 64'(1));
        chk("latency", 64'(n), 64'(8));
        drain("t1b_drain");

        // Simultaneous requests after reset: port 0 first
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        mdl_delay = 2;
        sbq.push_back(mk(1'b0, 5'd7,  5'd9,  1'b0, 1'b0));
        sbq.push_back(mk(1'b1, 5'h1F, 5'h10, 1'b1, 1'b0));
        a_0 = 5'd7;  b_0 = 5'd9;  op_0 = 1'b0;
        a_1 = 5'h1F; b_1 = 5'h10; op_1 = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1;
        wait_sig(0, "t2_grant0");
        req_0 = 1'b0;
        wait_sig(1, "t2_grant1");
        req_1 = 1'b0;
        drain("t2_drain");
        repeat (2) @(negedge clk);

        // req_1 held, req_0 raised mid-operation: port 0 next
        mdl_delay = 3;
        a_1 = 5'd11; b_1 = 5'd2; op_1 = 1'b0;
        a_0 = 5'd4;  b_0 = 5'h1D; op_0 = 1'b1;
        sbq.push_back(mk(1'b1, 5'd11, 5'd2, 1'b0, 1'b0));
        req_1 = 1'b1;
        wait_sig(1, "t3_grant1a");
        sbq.push_back(mk(1'b0, 5'd4, 5'h1D, 1'b1, 1'b0));
        req_0 = 1'b1;
        wait_sig(0, "t3_grant0");
        req_0 = 1'b0;
        sbq.push_back(mk(1'b1, 5'd11, 5'd2, 1'b0, 1'b0));
        wait_sig(1, "t3_grant1b");
        req_1 = 1'b0;
        drain("t3_drain");
        repeat (2) @(negedge clk);

        // Reset asserted during WAIT
        mdl_stuck = 1'b1;
        a_0 = 5'd6; b_0 = 5'd5; op_0 = 1'b1;
        sbq.push_back(mk(1'b0, 5'd6, 5'd5, 1'b1, 1'b0));
        req_0 = 1'b1;
        wait_sig(0, "t4_grant");
        req_0 = 1'b0;
        wait_sig(2, "t4_start");
        repeat (2) @(negedge clk);
        chk("t4_pre_busy", 64'({busy, grant_0, mul_op}), 64'(3'b111));
        #2 reset = 1'b0;
        #1;
        chk("t4_rst_outs", 64'({busy, grant_0, grant_1, mul_load, mul_start, mul_op, done_0, done_1}), 64'(0));
        chk("t4_rst_data", 64'(mul_data), 64'(0));
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mdl_stuck = 1'b0;
        mdl_delay = 2;
        repeat (2) @(negedge clk);
        chk("t4_idle", 64'({busy, mul_load, mul_start}), 64'(0));
        a_0 = 5'd2; b_0 = 5'd3; op_0 = 1'b0;
        sbq.push_back(mk(1'b0, 5'd2, 5'd3, 1'b0, 1'b0));
        req_0 = 1'b1;
        @(negedge clk);
        chk("t4_restart_grant", 64'({busy, grant_0, mul_load}), 64'(3'b110));
        @(negedge clk);
        chk("t4_restart_load", 64'({mul_load, mul_data}), 64'({1'b1, 5'd2}));
        req_0 = 1'b0;
        drain("t4_drain");
        repeat (2) @(negedge clk);

        // Operand change after GRANT is ignored
        mdl_delay = 1;
        a_0 = 5'd7; b_0 = 5'd2; op_0 = 1'b0;
        sbq.push_back(mk(1'b0, 5'd7, 5'd2, 1'b0, 1'b0));
        req_0 = 1'b1;
        wait_sig(0, "t5_grant");
        @(posedge clk);
        #1 a_0 = 5'h11; b_0 = 5'h13; op_0 = 1'b1;
        @(negedge clk);
        chk("t5_latched_a", 64'({mul_load, mul_data}), 64'({1'b1, 5'd7}));
        req_0 = 1'b0;
        drain("t5_drain");
        repeat (2) @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
        // Timeout with mul_ready stuck low, then a clean operation
        mdl_stuck = 1'b1;
        a_0 = 5'd9; b_0 = 5'd3; op_0 = 1'b0;
        sbq.push_back(mk(1'b0, 5'd9, 5'd3, 1'b0, 1'b1));
        req_0 = 1'b1;
        wait_sig(0, "t6_grant");
        req_0 = 1'b0;
        wait_sig(2, "t6_start");
        n = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (done_0 | done_1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_done_seen", 64'(seen), 64'(1));
        chk("t6_wait_cycles", 64'(n - 1), 64'(TO));
        chk("t6_error", 64'({error, result}), 64'({1'b1, 10'h000}));
        drain("t6_drain");
        repeat (2) @(negedge clk);
        mdl_stuck = 1'b0;
        mdl_delay = 2;
        a_0 = 5'd3; b_0 = 5'd3;
        sbq.push_back(mk(1'b0, 5'd3, 5'd3, 1'b0, 1'b0));
        req_0 = 1'b1;
        wait_sig(0, "t6b_grant");
        req_0 = 1'b0;
        drain("t6b_drain");
        @(negedge clk);
        chk("t6b_error_clr", 64'(error), 64'(0));
`endif

        repeat (3) @(negedge clk);
        chk("final_idle", 64'({busy, grant_0, grant_1}), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
